// File: rtl/ysyx_23060201_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_lsu_if
// Description : Bundle of the LSU's three handshake channels: the EXU-side
//               input, the memory request/response bus and the GPR write-back.
//               "slave" is the LSU's view, "master" is the surrounding
//               pipeline/bus view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_23060201_lsu_if;
    // EXU -> LSU
    logic        in_valid;
    logic        in_ready;
    logic        in_ren;
    logic        in_wen;
    logic        in_gpr_wen;
    logic [2:0]  in_func3;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_res;
    logic [31:0] in_wdata;
    // LSU <-> memory bus
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    // LSU -> register file
    logic        out_valid;
    logic        out_ready;
    logic        out_gpr_wen;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic        out_err;

    modport slave (
        input  in_valid, in_ren, in_wen, in_gpr_wen, in_func3, in_rd,
               in_alu_res, in_wdata,
        output in_ready,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
               mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output out_valid, out_gpr_wen, out_waddr, out_wdata, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_ren, in_wen, in_gpr_wen, in_func3, in_rd,
               in_alu_res, in_wdata,
        input  in_ready,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
               mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  out_valid, out_gpr_wen, out_waddr, out_wdata, out_err,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060201_lsu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060201_lsu
// Description : Single-outstanding load/store unit. Aligns store lanes,
//               extracts/extends load data, detects illegal/misaligned
//               accesses and bus timeouts, and produces the GPR write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060201_lsu #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    ysyx_23060201_lsu_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic             req_wen_q, req_wen_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [3:0]       req_wmask_q, req_wmask_d;
    logic             out_gpr_wen_q, out_gpr_wen_d;
    logic [4:0]       out_waddr_q, out_waddr_d;
    logic [31:0]      out_wdata_q, out_wdata_d;
    logic             out_err_q, out_err_d;

    logic [3:0]       st_mask;
    logic [31:0]      st_data;
    logic             acc_bad;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             tmo_hit;

    // Store lane placement and legality/alignment decode of the incoming op
    always_comb begin
        st_mask = 4'b0000;
        st_data = bus.in_wdata;
        case (bus.in_func3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << bus.in_alu_res[1:0];
                st_data = {4{bus.in_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {bus.in_alu_res[1], 1'b0};
                st_data = {2{bus.in_wdata[15:0]}};
            end
            2'b10:   st_mask = 4'b1111;
            default: st_mask = 4'b0000;
        endcase

        acc_bad = 1'b0;
        if (bus.in_ren && bus.in_wen) begin
            acc_bad = 1'b1;
        end else if (bus.in_ren) begin
            acc_bad = !(bus.in_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else begin
            acc_bad = !(bus.in_func3 inside {3'b000, 3'b001, 3'b010});
        end
        if (bus.in_func3[1:0] == 2'b01 && bus.in_alu_res[0])
            acc_bad = 1'b1;
        if (bus.in_func3[1:0] == 2'b10 && bus.in_alu_res[1:0] != 2'b00)
            acc_bad = 1'b1;
    end

    // Load byte/half selection and sign/zero extension of the returned word
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.mem_rsp_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rsp_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rsp_rdata[23:16];
            default: ld_byte = bus.mem_rsp_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.mem_rsp_rdata[31:16] : bus.mem_rsp_rdata[15:0];
        case (func3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.mem_rsp_rdata;
        endcase
    end

    // Counter started at REQ entry; this is the TIMEOUT_CYC-th REQ/WAIT cycle
    assign tmo_hit = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and next-data logic of the transaction FSM
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        func3_d       = func3_q;
        off_d         = off_q;
        req_wen_d     = req_wen_q;
        req_addr_d    = req_addr_q;
        req_wdata_d   = req_wdata_q;
        req_wmask_d   = req_wmask_q;
        out_gpr_wen_d = out_gpr_wen_q;
        out_waddr_d   = out_waddr_q;
        out_wdata_d   = out_wdata_q;
        out_err_d     = out_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    func3_d       = bus.in_func3;
                    off_d         = bus.in_alu_res[1:0];
                    out_waddr_d   = bus.in_rd;
                    out_wdata_d   = bus.in_alu_res;
                    out_gpr_wen_d = 1'b0;
                    out_err_d     = 1'b0;
                    if (!bus.in_ren && !bus.in_wen) begin
                        out_gpr_wen_d = bus.in_gpr_wen;
                        state_d       = S_RESP;
                    end else if (acc_bad) begin
                        out_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        req_wen_d   = bus.in_wen;
                        req_addr_d  = {bus.in_alu_res[31:2], 2'b00};
                        req_wdata_d = bus.in_wen ? st_data : 32'd0;
                        req_wmask_d = bus.in_wen ? st_mask : 4'b0000;
                        cnt_d       = '0;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    out_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_rsp_valid) begin
                    out_gpr_wen_d = !req_wen_q;
                    if (!req_wen_q)
                        out_wdata_d = ld_data;
                    state_d = S_RESP;
                end else if (tmo_hit) begin
                    out_err_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            func3_q       <= 3'd0;
            off_q         <= 2'd0;
            req_wen_q     <= 1'b0;
            req_addr_q    <= 32'd0;
            req_wdata_q   <= 32'd0;
            req_wmask_q   <= 4'd0;
            out_gpr_wen_q <= 1'b0;
            out_waddr_q   <= 5'd0;
            out_wdata_q   <= 32'd0;
            out_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            func3_q       <= func3_d;
            off_q         <= off_d;
            req_wen_q     <= req_wen_d;
            req_addr_q    <= req_addr_d;
            req_wdata_q   <= req_wdata_d;
            req_wmask_q   <= req_wmask_d;
            out_gpr_wen_q <= out_gpr_wen_d;
            out_waddr_q   <= out_waddr_d;
            out_wdata_q   <= out_wdata_d;
            out_err_q     <= out_err_d;
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_req_wen   = req_wen_q;
    assign bus.mem_req_addr  = req_addr_q;
    assign bus.mem_req_wdata = req_wdata_q;
    assign bus.mem_req_wmask = req_wmask_q;
    assign bus.out_valid     = (state_q == S_RESP);
    assign bus.out_gpr_wen   = out_gpr_wen_q;
    assign bus.out_waddr     = out_waddr_q;
    assign bus.out_wdata     = out_wdata_q;
    assign bus.out_err       = out_err_q;
endmodule
`default_nettype wire
